// File: rtl/svm_knn_acc_ctrl.sv
// Sequencer for the SVM/KNN accelerator: start detection, feature-memory streaming,
// result wait with timeout, and done/busy/error reporting.
module svm_knn_acc_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [1:0]        reg_start,
    input  logic              logic_op,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              dp_clr,
    output logic              dp_en,
    output logic              dp_last,
    output logic              dp_mode,
    output logic              dp_op,
    input  logic              dp_res_vld,
    input  logic [31:0]       dp_res,
    output logic [31:0]       result,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT_DATA, S_WAIT_RES, S_DONE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cmd_q;
    logic [CNT_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_iss_cnt;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_mem_req;
    logic              r_dp_clr;
    logic              r_dp_mode;
    logic              r_dp_op;
    logic              r_done;
    logic              r_busy;
    logic [31:0]       r_result;
    logic [1:0]        r_err;

    logic w_start;
    logic w_dp_en;
    logic w_dp_last;

    assign w_start   = (r_cmd_q == 2'b00) && (reg_start == 2'b01 || reg_start == 2'b10)
                       && (r_state == S_IDLE);
    // Returns arriving outside the transfer window (e.g. after an abort) are dropped here.
    assign w_dp_en   = mem_rvalid && (r_state == S_FETCH || r_state == S_WAIT_DATA);
    assign w_dp_last = w_dp_en && (r_rx_cnt == r_len - CNT_W'(1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_cmd_q   <= 2'b00;
            r_len     <= '0;
            r_base    <= '0;
            r_iss_cnt <= '0;
            r_rx_cnt  <= '0;
            r_tmo     <= '0;
            r_mem_req <= 1'b0;
            r_dp_clr  <= 1'b0;
            r_dp_mode <= 1'b0;
            r_dp_op   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_result  <= '0;
            r_err     <= 2'b00;
        end else begin
            r_cmd_q  <= reg_start;
            r_dp_clr <= 1'b0;
            r_done   <= 1'b0;
            if (w_dp_en) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
            end
            if (reg_start == 2'b11 && r_state != S_IDLE) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_mem_req <= 1'b0;
                r_err     <= 2'b11;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_len     <= cfg_len;
                            r_base    <= cfg_base;
                            r_dp_mode <= reg_start[1];
                            r_dp_op   <= logic_op;
                            r_iss_cnt <= '0;
                            r_rx_cnt  <= '0;
                            r_busy    <= 1'b1;
                            if (cfg_len == '0) begin
                                r_err   <= 2'b01;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_err    <= 2'b00;
                                r_dp_clr <= 1'b1;
                                r_state  <= S_CLEAR;
                            end
                        end else if (r_cmd_q == 2'b00 && reg_start == 2'b11) begin
                            r_err <= 2'b01;
                        end
                    end
                    S_CLEAR: begin
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (mem_gnt) begin
                            r_iss_cnt <= r_iss_cnt + CNT_W'(1);
                            if (r_iss_cnt == r_len - CNT_W'(1)) begin
                                r_mem_req <= 1'b0;
                                r_state   <= S_WAIT_DATA;
                            end
                        end
                    end
                    S_WAIT_DATA: begin
                        if (w_dp_last || r_rx_cnt == r_len) begin
                            r_tmo   <= '0;
                            r_state <= S_WAIT_RES;
                        end
                    end
                    S_WAIT_RES: begin
                        // A result in the final allowed cycle takes priority over the timeout.
                        if (dp_res_vld) begin
                            r_result <= dp_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (r_tmo == TMO_W'(TMO_CYC - 1)) begin
                            r_err   <= 2'b10;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_base + r_iss_cnt[ADDR_W-1:0];
    assign dp_clr   = r_dp_clr;
    assign dp_en    = w_dp_en;
    assign dp_last  = w_dp_last;
    assign dp_mode  = r_dp_mode;
    assign dp_op    = r_dp_op;
    assign result   = r_result;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
endmodule

// File: tb/tb_svm_knn_acc_ctrl.sv
// Bench for svm_knn_acc_ctrl: directed and randomized transactions against a
// transaction-level expectation (address list, beat counts, result/error, pulse timing).
module tb_svm_knn_acc_ctrl;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;
    localparam int TMO    = 255;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [1:0]        reg_start = 2'b00;
    logic              logic_op = 1'b0;
    logic [CNT_W-1:0]  cfg_len = '0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic              dp_clr, dp_en, dp_last, dp_mode, dp_op;
    logic              dp_res_vld = 1'b0;
    logic [31:0]       dp_res = '0;
    logic [31:0]       result;
    logic              busy, done;
    logic [1:0]        err;

    svm_knn_acc_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .reg_start(reg_start), .logic_op(logic_op),
        .cfg_len(cfg_len), .cfg_base(cfg_base), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .dp_clr(dp_clr), .dp_en(dp_en),
        .dp_last(dp_last), .dp_mode(dp_mode), .dp_op(dp_op), .dp_res_vld(dp_res_vld),
        .dp_res(dp_res), .result(result), .busy(busy), .done(done), .err(err)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gnt_pol = 0;
    int lat = 1;
    int ret_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    int en_cnt, last_cnt, last_idx, done_cnt, clr_cnt, hold_viol, req_cnt;
    int last_en_cyc, done_cyc, clr_cyc, first_req_cyc;
    logic prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0] m_result = '0;

    task automatic clr_logs();
        addr_log.delete();
        en_cnt = 0; last_cnt = 0; last_idx = 0; done_cnt = 0; clr_cnt = 0;
        hold_viol = 0; req_cnt = 0;
        last_en_cyc = -1; done_cyc = -1; clr_cyc = -1; first_req_cyc = -1;
    endtask

    // Memory model + observer: drives gnt/rvalid at negedge, samples 1 time unit later.
    initial begin : responder
        clr_logs();
        forever begin
            @(negedge PCLK);
            cyc++;
            case (gnt_pol)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = cyc[0];
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
            mem_rvalid = 1'b0;
            if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                void'(ret_q.pop_front());
                mem_rvalid = 1'b1;
            end
            #1;
            if (PRESETn && prev_wait && (!mem_req || mem_addr != prev_addr)) hold_viol++;
            prev_wait = mem_req && !mem_gnt;
            prev_addr = mem_addr;
            if (mem_req && mem_gnt) begin
                ret_q.push_back(cyc + lat);
                addr_log.push_back(mem_addr);
            end
            if (mem_req) begin
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (dp_en) begin en_cnt++; last_en_cyc = cyc; end
            if (dp_last) begin last_cnt++; last_idx = en_cnt; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (dp_clr) begin clr_cnt++; clr_cyc = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge PCLK);
            #2;
        end
    endtask

    // res_k: WAIT_RES cycle (1-based, first cycle after the last beat) carrying dp_res_vld; 0 = never.
    task automatic run_txn(input logic [1:0] kind, input int n, input logic [ADDR_W-1:0] base,
                           input logic op, input int pol, input int l, input int res_k,
                           input logic [31:0] val, input bit poke, input string tag);
        int s;
        int waitc;
        logic [1:0] exp_err;
        logic [ADDR_W-1:0] exp_a;
        gnt_pol = pol;
        lat = l;
        clr_logs();
        cfg_len = CNT_W'(n);
        cfg_base = base;
        logic_op = op;
        reg_start = kind;
        s = cyc;
        step(1);
        reg_start = 2'b00;
        cfg_len = CNT_W'($urandom);
        cfg_base = ADDR_W'($urandom);
        logic_op = ~op;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (poke) begin
            step(2);
            reg_start = 2'b10;
            step(1);
            reg_start = 2'b00;
        end
        waitc = 0;
        while (en_cnt < n && waitc < 500) begin step(1); waitc++; end
        if (res_k > 0) begin
            while (cyc < last_en_cyc + res_k && waitc < 1000) begin step(1); waitc++; end
            dp_res = val;
            dp_res_vld = 1'b1;
            step(1);
            dp_res_vld = 1'b0;
            dp_res = $urandom;
        end
        while (done_cnt == 0 && waitc < 1500) begin step(1); waitc++; end
        step(2);

        exp_err = (res_k >= 1 && res_k <= TMO) ? 2'b00 : 2'b10;
        if (exp_err == 2'b00) m_result = val;
        chk({tag, "_ngrant"}, 32'(addr_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_a = ADDR_W'((int'(base) + i) % (1 << ADDR_W));
            chk($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(exp_a));
        end
        chk({tag, "_en_cnt"}, 32'(en_cnt), 32'(n));
        chk({tag, "_last_cnt"}, 32'(last_cnt), 32'd1);
        chk({tag, "_last_idx"}, 32'(last_idx), 32'(n));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_en_cyc),
            (exp_err == 2'b00) ? 32'(res_k + 1) : 32'(TMO + 1));
        chk({tag, "_result"}, result, m_result);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_mode"}, 32'(dp_mode), 32'(kind[1]));
        chk({tag, "_op"}, 32'(dp_op), 32'(op));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_clr_cnt"}, 32'(clr_cnt), 32'd1);
        chk({tag, "_clr_lat"}, 32'(clr_cyc - s), 32'd1);
        chk({tag, "_req_lat"}, 32'(first_req_cyc - clr_cyc), 32'd1);
        chk({tag, "_hold"}, 32'(hold_viol), 32'd0);
    endtask

    initial begin : main
        int waitc;
        step(3);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_clr", 32'(dp_clr), 32'd0);
        chk("rst_mode", 32'(dp_mode), 32'd0);
        PRESETn = 1'b1;
        step(3);

        run_txn(2'b01, 4, 10'h3FE, 1'b1, 0, 1, 1, 32'hDEADBEEF, 1'b0, "svm_wrap");
        step(3);

        clr_logs();
        reg_start = 2'b11;
        step(1);
        chk("ill_busy0", 32'(busy), 32'd0);
        step(1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_busy1", 32'(busy), 32'd0);
        reg_start = 2'b00;
        step(2);
        chk("ill_done", 32'(done_cnt), 32'd0);
        chk("ill_clr", 32'(clr_cnt), 32'd0);

        run_txn(2'b10, 3, 10'h155, 1'b0, 1, 3, $urandom_range(1, 8), $urandom, 1'b0, "knn_alt");
        step(3);

        clr_logs();
        cfg_len = '0;
        reg_start = 2'b01;
        step(1);
        reg_start = 2'b00;
        waitc = 0;
        while (done_cnt == 0 && waitc < 50) begin step(1); waitc++; end
        step(2);
        chk("n0_req", 32'(req_cnt), 32'd0);
        chk("n0_done", 32'(done_cnt), 32'd1);
        chk("n0_err", 32'(err), 32'd1);
        chk("n0_busy", 32'(busy), 32'd0);
        chk("n0_result", result, m_result);

        run_txn(2'b01, 6, ADDR_W'($urandom), 1'b1, 2, 2, 3, $urandom, 1'b1, "restart");
        step(3);

        clr_logs();
        gnt_pol = 0;
        lat = 6;
        cfg_len = 16'd4;
        cfg_base = ADDR_W'($urandom);
        reg_start = 2'b01;
        step(1);
        reg_start = 2'b00;
        waitc = 0;
        while (addr_log.size() < 4 && waitc < 50) begin step(1); waitc++; end
        step(1);
        chk("abt_req_off", 32'(mem_req), 32'd0);
        reg_start = 2'b11;
        step(1);
        chk("abt_busy", 32'(busy), 32'd0);
        chk("abt_err", 32'(err), 32'd3);
        reg_start = 2'b00;
        step(12);
        chk("abt_no_en", 32'(en_cnt), 32'd0);
        chk("abt_no_done", 32'(done_cnt), 32'd0);
        chk("abt_err_hold", 32'(err), 32'd3);
        chk("abt_ret_seen", 32'(ret_q.size()), 32'd0);

        run_txn(2'b10, 2, ADDR_W'($urandom), 1'b0, 0, 1, 0, $urandom, 1'b0, "timeout");
        step(3);
        run_txn(2'b01, 2, ADDR_W'($urandom), 1'b1, 0, 1, TMO, $urandom, 1'b0, "res_at_255");
        step(3);
        run_txn(2'b10, 2, ADDR_W'($urandom), 1'b1, 0, 2, TMO + 1, $urandom, 1'b0, "res_at_256");
        step(3);

        for (int t = 0; t < 5; t++) begin
            run_txn(2'($urandom_range(1, 2)), $urandom_range(1, 12), ADDR_W'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 4),
                    $urandom_range(1, 10), $urandom, 1'b0, $sformatf("rnd%0d", t));
            step(3);
        end

        clr_logs();
        gnt_pol = 0;
        lat = 1;
        cfg_len = 16'd8;
        cfg_base = 10'h010;
        logic_op = 1'b1;
        reg_start = 2'b10;
        step(1);
        reg_start = 2'b00;
        waitc = 0;
        while (addr_log.size() < 3 && waitc < 50) begin step(1); waitc++; end
        step(1);
        PRESETn = 1'b0;
        #1;
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_en", 32'(dp_en), 32'd0);
        chk("mrst_last", 32'(dp_last), 32'd0);
        chk("mrst_clr", 32'(dp_clr), 32'd0);
        chk("mrst_mode", 32'(dp_mode), 32'd0);
        chk("mrst_op", 32'(dp_op), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_result", result, 32'd0);
        step(3);
        ret_q.delete();
        chk("mrst_no_done", 32'(done_cnt), 32'd0);
        PRESETn = 1'b1;
        step(3);
        chk("mrst_idle_busy", 32'(busy), 32'd0);
        chk("mrst_idle_req", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
